// File: rtl/kf6845_sync_monitor.sv
// kf6845_sync_monitor: display-side monitor for 6845 CRTC sync outputs.
// Measures line period, HSYNC width, lines per field, VSYNC width and
// displayed lines. Classifies each VSYNC rise as aligned or half-line to
// detect interlace. Runs a SEARCH/ACQUIRE/LOCKED lock FSM over field history.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   video_clock_enable  tick qualifier; nothing samples or counts without it
//   hsync, vsync        CRTC syncs, active high
//   display_enable      CRTC DISPEN, active high
//   h_period            enabled ticks between HSYNC rises (latched per field)
//   hsync_width         enabled ticks HSYNC high (latched per field)
//   v_lines             HSYNC rises in the last field
//   vsync_lines         HSYNC rises during the last VSYNC pulse
//   disp_lines          lines in the last field with DISPEN seen
//   field_odd           last VSYNC rise was line-aligned
//   interlaced          alignment differed between the last two fields
//   field_done          one-clock pulse per field boundary outside SEARCH
//   locked              LOCK_FIELDS consecutive matching fields
module kf6845_sync_monitor #(
    parameter int unsigned HW          = 12,
    parameter int unsigned LW          = 10,
    parameter int unsigned LOCK_FIELDS = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          video_clock_enable,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          display_enable,
    output logic [HW-1:0] h_period,
    output logic [HW-1:0] hsync_width,
    output logic [LW-1:0] v_lines,
    output logic [LW-1:0] vsync_lines,
    output logic [LW-1:0] disp_lines,
    output logic          field_odd,
    output logic          interlaced,
    output logic          field_done,
    output logic          locked
);

    localparam int unsigned MW = $clog2(LOCK_FIELDS + 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
        return (v == '1) ? v : v + HW'(1);
    endfunction

    function automatic logic [LW-1:0] sat_inc_l(input logic [LW-1:0] v);
        return (v == '1) ? v : v + LW'(1);
    endfunction

    // Registers
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [HW-1:0] h_pos_q, h_pos_d;
    logic [HW-1:0] h_meas_q, h_meas_d;
    logic [HW-1:0] hs_cnt_q, hs_cnt_d;
    logic [HW-1:0] hw_meas_q, hw_meas_d;
    logic          de_seen_q, de_seen_d;
    logic [LW-1:0] disp_cnt_q, disp_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [LW-1:0] vs_cnt_q, vs_cnt_d;
    logic [HW-1:0] h_period_q, h_period_d;
    logic [HW-1:0] hsync_width_q, hsync_width_d;
    logic [LW-1:0] v_lines_q, v_lines_d;
    logic [LW-1:0] vsync_lines_q, vsync_lines_d;
    logic [LW-1:0] disp_lines_q, disp_lines_d;
    logic          field_odd_q, field_odd_d;
    logic          interlaced_q, interlaced_d;
    logic          field_done_q, field_done_d;
    logic          locked_q, locked_d;
    state_t        state_q, state_d;
    logic [1:0]    hist_cnt_q, hist_cnt_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    // Only the history entries the lock comparison reads are kept.
    logic [HW-1:0] hist0_h_q, hist0_h_d;
    logic [LW-1:0] hist0_l_q, hist0_l_d;
    logic [LW-1:0] hist1_l_q, hist1_l_d;

    // Edge detection and values as seen after this tick's HSYNC processing
    logic          hs_rise, hs_fall, vs_rise, vs_fall;
    logic [HW-1:0] h_meas_new, h_pos_eff;
    logic [LW-1:0] line_cnt_new;
    logic          aligned, timeout;

    assign hs_rise = video_clock_enable & hsync & ~hs_q;
    assign hs_fall = video_clock_enable & ~hsync & hs_q;
    assign vs_rise = video_clock_enable & vsync & ~vs_q;
    assign vs_fall = video_clock_enable & ~vsync & vs_q;

    assign h_meas_new   = hs_rise ? sat_inc_h(h_pos_q) : h_meas_q;
    assign line_cnt_new = hs_rise ? sat_inc_l(line_cnt_q) : line_cnt_q;
    // A coincident HSYNC rise means the new field starts at position 0.
    assign h_pos_eff    = hs_rise ? '0 : h_pos_q;
    assign aligned      = h_pos_eff < (h_meas_new >> 2);
    assign timeout      = video_clock_enable & ~hs_rise & (h_pos_q == '1);

    // Measurement datapath
    always_comb begin
        hs_d          = hs_q;
        vs_d          = vs_q;
        h_pos_d       = h_pos_q;
        h_meas_d      = h_meas_q;
        hs_cnt_d      = hs_cnt_q;
        hw_meas_d     = hw_meas_q;
        de_seen_d     = de_seen_q;
        disp_cnt_d    = disp_cnt_q;
        line_cnt_d    = line_cnt_q;
        vs_cnt_d      = vs_cnt_q;
        h_period_d    = h_period_q;
        hsync_width_d = hsync_width_q;
        v_lines_d     = v_lines_q;
        vsync_lines_d = vsync_lines_q;
        disp_lines_d  = disp_lines_q;
        field_odd_d   = field_odd_q;
        interlaced_d  = interlaced_q;

        if (video_clock_enable) begin
            hs_d       = hsync;
            vs_d       = vsync;
            h_meas_d   = h_meas_new;
            line_cnt_d = line_cnt_new;
            h_pos_d    = hs_rise ? '0 : sat_inc_h(h_pos_q);

            if (hsync) begin
                hs_cnt_d = sat_inc_h(hs_cnt_q);
            end
            if (hs_fall) begin
                hw_meas_d = hs_cnt_q;
                hs_cnt_d  = '0;
            end

            // DISPEN on the rise tick itself belongs to the new line.
            if (hs_rise) begin
                if (de_seen_q) begin
                    disp_cnt_d = sat_inc_l(disp_cnt_q);
                end
                de_seen_d = display_enable;
            end else if (display_enable) begin
                de_seen_d = 1'b1;
            end

            if (hs_rise && vsync) begin
                vs_cnt_d = sat_inc_l(vs_cnt_q);
            end
            if (vs_fall) begin
                vsync_lines_d = vs_cnt_q;
            end

            // Field boundary: latch counts including any coincident line.
            if (vs_rise) begin
                v_lines_d     = line_cnt_new;
                line_cnt_d    = '0;
                disp_lines_d  = disp_cnt_d;
                disp_cnt_d    = '0;
                vs_cnt_d      = hs_rise ? LW'(1) : '0;
                h_period_d    = h_meas_new;
                hsync_width_d = hw_meas_d;
                field_odd_d   = aligned;
                interlaced_d  = aligned != field_odd_q;
            end
        end
    end

    // Lock FSM next-state and outputs
    always_comb begin
        state_d      = state_q;
        hist_cnt_d   = hist_cnt_q;
        match_cnt_d  = match_cnt_q;
        hist0_h_d    = hist0_h_q;
        hist0_l_d    = hist0_l_q;
        hist1_l_d    = hist1_l_q;
        locked_d     = locked_q;
        field_done_d = 1'b0;

        if (vs_rise) begin
            case (state_q)
                SEARCH: begin
                    state_d     = ACQUIRE;
                    hist_cnt_d  = 2'd0;
                    match_cnt_d = '0;
                end
                default: begin
                    field_done_d = 1'b1;
                    if (hist_cnt_q == 2'd2) begin
                        // Line count compared two fields back to keep parity.
                        if ((h_meas_new == hist0_h_q) && (line_cnt_new == hist1_l_q)) begin
                            if (match_cnt_q >= MW'(LOCK_FIELDS - 1)) begin
                                match_cnt_d = MW'(LOCK_FIELDS);
                                state_d     = LOCKED;
                                locked_d    = 1'b1;
                            end else begin
                                match_cnt_d = match_cnt_q + MW'(1);
                            end
                        end else begin
                            match_cnt_d = '0;
                            locked_d    = 1'b0;
                            state_d     = ACQUIRE;
                        end
                    end else begin
                        hist_cnt_d = hist_cnt_q + 2'd1;
                    end
                    hist1_l_d = hist0_l_q;
                    hist0_l_d = line_cnt_new;
                    hist0_h_d = h_meas_new;
                end
            endcase
        end

        // Lost HSYNC: drop lock, latched measurements hold.
        if (timeout) begin
            state_d      = SEARCH;
            locked_d     = 1'b0;
            match_cnt_d  = '0;
            field_done_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            h_pos_q       <= '0;
            h_meas_q      <= '0;
            hs_cnt_q      <= '0;
            hw_meas_q     <= '0;
            de_seen_q     <= 1'b0;
            disp_cnt_q    <= '0;
            line_cnt_q    <= '0;
            vs_cnt_q      <= '0;
            h_period_q    <= '0;
            hsync_width_q <= '0;
            v_lines_q     <= '0;
            vsync_lines_q <= '0;
            disp_lines_q  <= '0;
            field_odd_q   <= 1'b0;
            interlaced_q  <= 1'b0;
            field_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            state_q       <= SEARCH;
            hist_cnt_q    <= 2'd0;
            match_cnt_q   <= '0;
            hist0_h_q     <= '0;
            hist0_l_q     <= '0;
            hist1_l_q     <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            h_pos_q       <= h_pos_d;
            h_meas_q      <= h_meas_d;
            hs_cnt_q      <= hs_cnt_d;
            hw_meas_q     <= hw_meas_d;
            de_seen_q     <= de_seen_d;
            disp_cnt_q    <= disp_cnt_d;
            line_cnt_q    <= line_cnt_d;
            vs_cnt_q      <= vs_cnt_d;
            h_period_q    <= h_period_d;
            hsync_width_q <= hsync_width_d;
            v_lines_q     <= v_lines_d;
            vsync_lines_q <= vsync_lines_d;
            disp_lines_q  <= disp_lines_d;
            field_odd_q   <= field_odd_d;
            interlaced_q  <= interlaced_d;
            field_done_q  <= field_done_d;
            locked_q      <= locked_d;
            state_q       <= state_d;
            hist_cnt_q    <= hist_cnt_d;
            match_cnt_q   <= match_cnt_d;
            hist0_h_q     <= hist0_h_d;
            hist0_l_q     <= hist0_l_d;
            hist1_l_q     <= hist1_l_d;
        end
    end

    assign h_period    = h_period_q;
    assign hsync_width = hsync_width_q;
    assign v_lines     = v_lines_q;
    assign vsync_lines = vsync_lines_q;
    assign disp_lines  = disp_lines_q;
    assign field_odd   = field_odd_q;
    assign interlaced  = interlaced_q;
    assign field_done  = field_done_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_kf6845_sync_monitor.sv
// Directed bench for kf6845_sync_monitor: synthetic CRTC fields with
// hand-computed expectations for measurements, interlace and lock.
module tb_kf6845_sync_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        video_clock_enable;
    logic        hsync;
    logic        vsync;
    logic        display_enable;
    logic [11:0] h_period;
    logic [11:0] hsync_width;
    logic [9:0]  v_lines;
    logic [9:0]  vsync_lines;
    logic [9:0]  disp_lines;
    logic        field_odd;
    logic        interlaced;
    logic        field_done;
    logic        locked;

    int total = 0;
    int bad   = 0;

    kf6845_sync_monitor #(.HW(12), .LW(10), .LOCK_FIELDS(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .video_clock_enable (video_clock_enable),
        .hsync              (hsync),
        .vsync              (vsync),
        .display_enable     (display_enable),
        .h_period           (h_period),
        .hsync_width        (hsync_width),
        .v_lines            (v_lines),
        .vsync_lines        (vsync_lines),
        .disp_lines         (disp_lines),
        .field_odd          (field_odd),
        .interlaced         (interlaced),
        .field_done         (field_done),
        .locked             (locked)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One enabled tick, optionally preceded by disabled cycles with junk inputs.
    task automatic tick(input logic h, input logic v, input logic d, input int gap);
        for (int g = 0; g < gap; g++) begin
            video_clock_enable = 1'b0;
            hsync              = 1'($urandom_range(0, 1));
            vsync              = 1'($urandom_range(0, 1));
            display_enable     = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        video_clock_enable = 1'b1;
        hsync              = h;
        vsync              = v;
        display_enable     = d;
        @(posedge clock); #1;
    endtask

    // One field: HSYNC 4 ticks at line start, VSYNC rises at tick voff of
    // line 0 for 2 lines, DISPEN on lines 2..9 after HSYNC.
    task automatic run_field(input int per, input int nl, input int voff, input int gap,
                             output logic fd, output logic lk);
        fd = 1'b0;
        lk = 1'b0;
        for (int l = 0; l < nl; l++) begin
            for (int t = 0; t < per; t++) begin
                int p;
                p = l * per + t;
                tick(t < 4, (p >= voff) && (p < 2 * per + voff), (l >= 2) && (l < 10) && (t >= 4), gap);
                if (p == voff) begin
                    fd = field_done;
                    lk = locked;
                end
            end
        end
    endtask

    task automatic do_reset();
        video_clock_enable = 1'b0;
        hsync              = 1'b0;
        vsync              = 1'b0;
        display_enable     = 1'b0;
        reset              = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic fd, lk;

        // Reset state
        reset = 1'b1; video_clock_enable = 1'b0;
        hsync = 1'b0; vsync = 1'b0; display_enable = 1'b0;
        #1;
        check("rst_h_period", 32'(h_period), 0);
        check("rst_v_lines", 32'(v_lines), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_field_done", 32'(field_done), 0);

        // 1: progressive stream
        do_reset();
        run_field(20, 10, 1, 0, fd, lk);
        check("s1_first_fd", 32'(fd), 0);
        run_field(20, 10, 1, 0, fd, lk);
        check("s1_second_fd", 32'(fd), 1);
        run_field(20, 10, 1, 0, fd, lk);
        run_field(20, 10, 1, 0, fd, lk);
        check("s1_lock4", 32'(lk), 0);
        run_field(20, 10, 1, 0, fd, lk);
        check("s1_lock5", 32'(lk), 1);
        check("s1_fd5", 32'(fd), 1);
        check("s1_h_period", 32'(h_period), 20);
        check("s1_hsync_width", 32'(hsync_width), 4);
        check("s1_v_lines", 32'(v_lines), 10);
        check("s1_vsync_lines", 32'(vsync_lines), 2);
        check("s1_disp_lines", 32'(disp_lines), 8);
        check("s1_field_odd", 32'(field_odd), 1);
        check("s1_interlaced", 32'(interlaced), 0);
        check("s1_fd_pulse_end", 32'(field_done), 0);

        // 3: period changes to 21 and stays
        run_field(21, 10, 1, 0, fd, lk);
        check("s3_lock6", 32'(lk), 1);
        run_field(21, 10, 1, 0, fd, lk);
        check("s3_unlock7", 32'(lk), 0);
        check("s3_fd7", 32'(fd), 1);
        check("s3_h_period7", 32'(h_period), 21);
        run_field(21, 10, 1, 0, fd, lk);
        check("s3_lock8", 32'(lk), 0);
        run_field(21, 10, 1, 0, fd, lk);
        check("s3_relock9", 32'(lk), 1);

        // 4: HSYNC lost long enough to saturate h_pos
        for (int i = 0; i < 4100; i++) tick(1'b0, 1'b0, 1'b0, 0);
        check("s4_locked", 32'(locked), 0);
        check("s4_hold_h_period", 32'(h_period), 21);
        check("s4_hold_v_lines", 32'(v_lines), 10);
        run_field(20, 10, 1, 0, fd, lk);
        check("s4_search_exit_fd", 32'(fd), 0);
        run_field(20, 10, 1, 0, fd, lk);
        check("s4_acquire_fd", 32'(fd), 1);
        check("s4_acquire_lock", 32'(lk), 0);

        // 2: interlace, VSYNC alternately at h_pos 0 and 10, 10/11 lines
        do_reset();
        run_field(20, 10, 1, 0, fd, lk);
        run_field(20, 11, 11, 0, fd, lk);
        run_field(20, 10, 1, 0, fd, lk);
        run_field(20, 11, 11, 0, fd, lk);
        check("s2_odd4", 32'(field_odd), 0);
        check("s2_il4", 32'(interlaced), 1);
        check("s2_v_lines4", 32'(v_lines), 10);
        check("s2_lock4", 32'(lk), 0);
        run_field(20, 10, 1, 0, fd, lk);
        check("s2_odd5", 32'(field_odd), 1);
        check("s2_il5", 32'(interlaced), 1);
        check("s2_v_lines5", 32'(v_lines), 11);
        check("s2_lock5", 32'(lk), 1);
        // Threshold h_meas>>2 = 5: h_pos 4 aligned, h_pos 5 half-line
        run_field(20, 10, 5, 0, fd, lk);
        check("s2_pos4_odd", 32'(field_odd), 1);
        check("s2_pos4_il", 32'(interlaced), 0);
        run_field(20, 10, 6, 0, fd, lk);
        check("s2_pos5_odd", 32'(field_odd), 0);
        check("s2_pos5_il", 32'(interlaced), 1);

        // 5: enable gaps, then coincident HSYNC/VSYNC rise
        do_reset();
        run_field(20, 10, 1, 0, fd, lk);
        run_field(20, 10, 1, 1, fd, lk);
        run_field(20, 10, 1, 1, fd, lk);
        run_field(20, 10, 1, 1, fd, lk);
        check("s5_gap_h_period", 32'(h_period), 20);
        check("s5_gap_v_lines", 32'(v_lines), 10);
        check("s5_gap_hsync_width", 32'(hsync_width), 4);
        check("s5_gap_disp", 32'(disp_lines), 8);
        run_field(20, 10, 0, 0, fd, lk);
        check("s5_coinc_fd", 32'(fd), 1);
        check("s5_coinc_lock", 32'(lk), 1);
        check("s5_coinc_v_lines", 32'(v_lines), 10);
        check("s5_coinc_disp", 32'(disp_lines), 8);
        check("s5_coinc_odd", 32'(field_odd), 1);
        check("s5_coinc_vsync_lines", 32'(vsync_lines), 2);

        // 6: reset mid-field while locked
        run_field(20, 4, 1, 0, fd, lk);
        check("s6_pre_lock", 32'(lk), 1);
        reset = 1'b1;
        #1;
        check("s6_rst_locked", 32'(locked), 0);
        check("s6_rst_h_period", 32'(h_period), 0);
        check("s6_rst_v_lines", 32'(v_lines), 0);
        check("s6_rst_disp", 32'(disp_lines), 0);
        do_reset();
        run_field(20, 10, 1, 0, fd, lk);
        check("s6_exit_fd", 32'(fd), 0);
        run_field(20, 10, 1, 0, fd, lk);
        run_field(20, 10, 1, 0, fd, lk);
        run_field(20, 10, 1, 0, fd, lk);
        check("s6_lock4", 32'(lk), 0);
        run_field(20, 10, 1, 0, fd, lk);
        check("s6_lock5", 32'(lk), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
